// File: rtl/alu_seq_fsm_pkg.sv
// Shared types and constants for the ALU instruction sequencer.
// Optional build macro: ALU_SEQ_SIGN_EXT_IMM_EN (sign-extended immediate).
package alu_seq_fsm_pkg;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_LOAD_A    = 4'd2,
        S_DRIVE_B   = 4'd3,
        S_LOAD_B    = 4'd4,
        S_LATCH     = 4'd5,
        S_DRIVE_OUT = 4'd6,
        S_WRITE     = 4'd7,
        S_DONE      = 4'd8,
        S_ERR       = 4'd9
    } state_t;

    localparam logic [3:0] OPC_ADDI = 4'b0000;
    localparam logic [3:0] OPC_SUBI = 4'b0001;
    localparam logic [3:0] OPC_ADD  = 4'b0010;
    localparam logic [3:0] OPC_SUB  = 4'b0011;

    // param1 occupies field slot 1, param2 slot 0 (slot n = [n*FIELD_W +: FIELD_W])
    localparam int P1_SLOT = 1;
    localparam int P2_SLOT = 0;

endpackage

// File: rtl/alu_seq_fsm_if.sv
// Issue handshake and datapath control bundle between decoder, sequencer and bus.
interface alu_seq_fsm_if #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 5
);
    logic                start;
    logic [DATA_W-1:0]   instruction;
    logic                busy;
    logic                done;
    logic                illegal;
    logic [NUM_REGS-1:0] rx_out;
    logic [NUM_REGS-1:0] rx_in;
    logic                alu_in0;
    logic                alu_in1;
    logic                alu_out_latch;
    logic                alu_out_en;
    logic                pc_inc;
    logic                imm_en;
    logic [DATA_W-1:0]   imm_out;

    modport master (
        output start, instruction,
        input  busy, done, illegal, rx_out, rx_in, alu_in0, alu_in1,
               alu_out_latch, alu_out_en, pc_inc, imm_en, imm_out
    );

    modport slave (
        input  start, instruction,
        output busy, done, illegal, rx_out, rx_in, alu_in0, alu_in1,
               alu_out_latch, alu_out_en, pc_inc, imm_en, imm_out
    );
endinterface

// File: rtl/alu_seq_fsm_reg_onehot_dec.sv
// Register index to one-hot enable decoder with range flag.
module reg_onehot_dec #(
    parameter int FIELD_W  = 6,
    parameter int NUM_REGS = 5
) (
    input  logic [FIELD_W-1:0]  idx,
    output logic [NUM_REGS-1:0] onehot,
    output logic                in_range
);

    // Out-of-range indices decode to all-zero, so they can never enable a register.
    always_comb begin
        onehot   = '0;
        in_range = (int'(idx) < NUM_REGS);
        for (int i = 0; i < NUM_REGS; i++) begin
            onehot[i] = (int'(idx) == i);
        end
    end

endmodule

// File: rtl/alu_seq_fsm.sv
// ALU instruction sequencer: immediate- and register-form ops with start/done handshake.
// Build macro ALU_SEQ_SIGN_EXT_IMM_EN selects sign- instead of zero-extended imm_out.
module alu_seq_fsm
    import alu_seq_fsm_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 5,
    parameter int OPC_W    = 4,
    parameter int FIELD_W  = 6
) (
    input  logic          clk,
    input  logic          rst,
    alu_seq_fsm_if.slave  bus
);

    localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(OPC_ADDI);
    localparam logic [OPC_W-1:0] OP_SUBI = OPC_W'(OPC_SUBI);
    localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(OPC_ADD);
    localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(OPC_SUB);

    function automatic logic [DATA_W-1:0] imm_ext(input logic [FIELD_W-1:0] f);
`ifdef ALU_SEQ_SIGN_EXT_IMM_EN
        return {{(DATA_W-FIELD_W){f[FIELD_W-1]}}, f};
`else
        return {{(DATA_W-FIELD_W){1'b0}}, f};
`endif
    endfunction

    state_t                state_r, state_nxt_s;
    logic [DATA_W-1:0]     instr_r, instr_nxt_s;
    logic                  accept_s;
    logic [OPC_W-1:0]      opc_in_s, opc_nxt_s;
    logic                  opc_valid_s, reg_form_nxt_s, idx_ok_s;
    logic [FIELD_W-1:0]    p1_s, p2_s;
    logic [NUM_REGS-1:0]   oh1_s, oh2_s;
    logic                  p1_ok_s, p2_ok_s;

    logic                  busy_s, done_s, illegal_s;
    logic [NUM_REGS-1:0]   rx_out_s, rx_in_s;
    logic                  alu_in0_s, alu_in1_s, alu_out_latch_s, alu_out_en_s;
    logic                  pc_inc_s, imm_en_s;
    logic [DATA_W-1:0]     imm_out_s;

    logic                  busy_r, done_r, illegal_r;
    logic [NUM_REGS-1:0]   rx_out_r, rx_in_r;
    logic                  alu_in0_r, alu_in1_r, alu_out_latch_r, alu_out_en_r;
    logic                  pc_inc_r, imm_en_r;
    logic [DATA_W-1:0]     imm_out_r;

    // Accept decision and the instruction copy that will be live next cycle.
    always_comb begin
        opc_in_s    = bus.instruction[DATA_W-1 -: OPC_W];
        opc_valid_s = (opc_in_s == OP_ADDI) || (opc_in_s == OP_SUBI) ||
                      (opc_in_s == OP_ADD)  || (opc_in_s == OP_SUB);
        accept_s    = bus.start && opc_valid_s &&
                      ((state_r == S_IDLE) || (state_r == S_DONE));
        if (accept_s) begin
            instr_nxt_s = bus.instruction;
        end else begin
            instr_nxt_s = instr_r;
        end
        opc_nxt_s      = instr_nxt_s[DATA_W-1 -: OPC_W];
        reg_form_nxt_s = (opc_nxt_s == OP_ADD) || (opc_nxt_s == OP_SUB);
        p1_s           = instr_nxt_s[P1_SLOT*FIELD_W +: FIELD_W];
        p2_s           = instr_nxt_s[P2_SLOT*FIELD_W +: FIELD_W];
    end

    reg_onehot_dec #(.FIELD_W(FIELD_W), .NUM_REGS(NUM_REGS)) u_dec_p1 (
        .idx      (p1_s),
        .onehot   (oh1_s),
        .in_range (p1_ok_s)
    );

    reg_onehot_dec #(.FIELD_W(FIELD_W), .NUM_REGS(NUM_REGS)) u_dec_p2 (
        .idx      (p2_s),
        .onehot   (oh2_s),
        .in_range (p2_ok_s)
    );

    // Next-state logic; immediate form never checks param2.
    always_comb begin
        idx_ok_s    = p1_ok_s && (!reg_form_nxt_s || p2_ok_s);
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE, S_DONE: begin
                if (accept_s) begin
                    state_nxt_s = idx_ok_s ? S_FETCH : S_ERR;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_FETCH:     state_nxt_s = S_LOAD_A;
            S_LOAD_A:    state_nxt_s = S_DRIVE_B;
            S_DRIVE_B:   state_nxt_s = S_LOAD_B;
            S_LOAD_B:    state_nxt_s = S_LATCH;
            S_LATCH:     state_nxt_s = S_DRIVE_OUT;
            S_DRIVE_OUT: state_nxt_s = S_WRITE;
            S_WRITE:     state_nxt_s = S_DONE;
            S_ERR:       state_nxt_s = S_IDLE;
            default:     state_nxt_s = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the next state so they register in step with it.
    always_comb begin
        busy_s          = (state_nxt_s != S_IDLE);
        done_s          = 1'b0;
        illegal_s       = 1'b0;
        rx_out_s        = '0;
        rx_in_s         = '0;
        alu_in0_s       = 1'b0;
        alu_in1_s       = 1'b0;
        alu_out_latch_s = 1'b0;
        alu_out_en_s    = 1'b0;
        pc_inc_s        = 1'b0;
        imm_en_s        = 1'b0;
        imm_out_s       = '0;
        case (state_nxt_s)
            S_FETCH: begin
                rx_out_s = oh1_s;
                pc_inc_s = 1'b1;
            end
            S_LOAD_A: begin
                rx_out_s  = oh1_s;
                alu_in0_s = 1'b1;
            end
            S_DRIVE_B, S_LOAD_B: begin
                alu_in1_s = (state_nxt_s == S_LOAD_B);
                if (reg_form_nxt_s) begin
                    rx_out_s = oh2_s;
                end else begin
                    imm_en_s  = 1'b1;
                    imm_out_s = imm_ext(p2_s);
                end
            end
            S_LATCH:     alu_out_latch_s = 1'b1;
            S_DRIVE_OUT: alu_out_en_s    = 1'b1;
            S_WRITE: begin
                alu_out_en_s = 1'b1;
                rx_in_s      = oh1_s;
            end
            S_DONE: done_s = 1'b1;
            S_ERR: begin
                done_s    = 1'b1;
                illegal_s = 1'b1;
            end
            default: busy_s = busy_s;
        endcase
    end

    // State, captured instruction and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r         <= S_IDLE;
            instr_r         <= '0;
            busy_r          <= 1'b0;
            done_r          <= 1'b0;
            illegal_r       <= 1'b0;
            rx_out_r        <= '0;
            rx_in_r         <= '0;
            alu_in0_r       <= 1'b0;
            alu_in1_r       <= 1'b0;
            alu_out_latch_r <= 1'b0;
            alu_out_en_r    <= 1'b0;
            pc_inc_r        <= 1'b0;
            imm_en_r        <= 1'b0;
            imm_out_r       <= '0;
        end else begin
            state_r         <= state_nxt_s;
            instr_r         <= instr_nxt_s;
            busy_r          <= busy_s;
            done_r          <= done_s;
            illegal_r       <= illegal_s;
            rx_out_r        <= rx_out_s;
            rx_in_r         <= rx_in_s;
            alu_in0_r       <= alu_in0_s;
            alu_in1_r       <= alu_in1_s;
            alu_out_latch_r <= alu_out_latch_s;
            alu_out_en_r    <= alu_out_en_s;
            pc_inc_r        <= pc_inc_s;
            imm_en_r        <= imm_en_s;
            imm_out_r       <= imm_out_s;
        end
    end

    assign bus.busy          = busy_r;
    assign bus.done          = done_r;
    assign bus.illegal       = illegal_r;
    assign bus.rx_out        = rx_out_r;
    assign bus.rx_in         = rx_in_r;
    assign bus.alu_in0       = alu_in0_r;
    assign bus.alu_in1       = alu_in1_r;
    assign bus.alu_out_latch = alu_out_latch_r;
    assign bus.alu_out_en    = alu_out_en_r;
    assign bus.pc_inc        = pc_inc_r;
    assign bus.imm_en        = imm_en_r;
    assign bus.imm_out       = imm_out_r;

endmodule

// File: tb/tb_alu_seq_fsm.sv
// Self-checking bench for alu_seq_fsm: vector table plus per-cycle expected-output scoreboard.
module tb_alu_seq_fsm;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        illegal;
        logic [4:0]  rx_out;
        logic [4:0]  rx_in;
        logic        alu_in0;
        logic        alu_in1;
        logic        alu_out_latch;
        logic        alu_out_en;
        logic        pc_inc;
        logic        imm_en;
        logic [15:0] imm_out;
    } obs_t;

    typedef struct {
        logic [15:0] instr;
        bit          acc;
        bit          ill;
        logic [4:0]  oh_a;
        logic [4:0]  oh_b;
        bit          reg_form;
        logic [15:0] imm;
    } vec_t;

`ifdef ALU_SEQ_SIGN_EXT_IMM_EN
    localparam logic [15:0] IMM_3F = 16'hFFFF;
`else
    localparam logic [15:0] IMM_3F = 16'h003F;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_seq_fsm_if #(.DATA_W(16), .NUM_REGS(5)) bus ();

    alu_seq_fsm #(.DATA_W(16), .NUM_REGS(5), .OPC_W(4), .FIELD_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    obs_t exp_q[$];
    obs_t cur_exp;
    int   n_vec = 0;
    int   n_err = 0;
    vec_t tbl[10];

    function automatic obs_t exp_cycle(vec_t v, int k);
        obs_t o;
        o      = '0;
        o.busy = 1'b1;
        if (v.ill) begin
            o.done    = 1'b1;
            o.illegal = 1'b1;
            return o;
        end
        case (k)
            1: begin o.rx_out = v.oh_a; o.pc_inc = 1'b1; end
            2: begin o.rx_out = v.oh_a; o.alu_in0 = 1'b1; end
            3, 4: begin
                if (v.reg_form) o.rx_out = v.oh_b;
                else begin o.imm_en = 1'b1; o.imm_out = v.imm; end
                o.alu_in1 = (k == 4);
            end
            5: o.alu_out_latch = 1'b1;
            6: o.alu_out_en = 1'b1;
            7: begin o.alu_out_en = 1'b1; o.rx_in = v.oh_a; end
            default: o.done = 1'b1;
        endcase
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.busy          = bus.busy;
        o.done          = bus.done;
        o.illegal       = bus.illegal;
        o.rx_out        = bus.rx_out;
        o.rx_in         = bus.rx_in;
        o.alu_in0       = bus.alu_in0;
        o.alu_in1       = bus.alu_in1;
        o.alu_out_latch = bus.alu_out_latch;
        o.alu_out_en    = bus.alu_out_en;
        o.pc_inc        = bus.pc_inc;
        o.imm_en        = bus.imm_en;
        o.imm_out       = bus.imm_out;
        return o;
    endfunction

    // One clock: drive inputs, advance, then compare against the scoreboard head (idle if empty).
    task automatic step(input bit s, input logic [15:0] ins, input bit r, input string tag);
        obs_t got;
        rst             = r;
        bus.start       = s;
        bus.instruction = ins;
        @(posedge clk);
        #1;
        if (!r) begin
            exp_q.delete();
            cur_exp = '0;
        end else if (exp_q.size() > 0) begin
            cur_exp = exp_q.pop_front();
        end else begin
            cur_exp = '0;
        end
        got = sample();
        n_vec++;
        if (got !== cur_exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, cur_exp);
        end
    endtask

    task automatic issue(input vec_t v, input string tag);
        if (v.acc && (cur_exp == '0 || (cur_exp.done && !cur_exp.illegal))) begin
            for (int k = 1; k <= (v.ill ? 1 : 8); k++) exp_q.push_back(exp_cycle(v, k));
        end
        step(1'b1, v.instr, 1'b1, tag);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 12 && exp_q.size() > 0; i++) step(1'b0, 16'h0000, 1'b1, tag);
        step(1'b0, 16'h0000, 1'b1, tag);
    endtask

    initial begin
        tbl[0] = '{16'h00C5, 1'b1, 1'b0, 5'b01000, 5'b00000, 1'b0, 16'h0005};
        tbl[1] = '{16'h2042, 1'b1, 1'b0, 5'b00010, 5'b00100, 1'b1, 16'h0000};
        tbl[2] = '{16'h0145, 1'b1, 1'b1, 5'b00000, 5'b00000, 1'b0, 16'h0000};
        tbl[3] = '{16'h3047, 1'b1, 1'b1, 5'b00000, 5'b00000, 1'b1, 16'h0000};
        tbl[4] = '{16'h1105, 1'b1, 1'b0, 5'b10000, 5'b00000, 1'b0, 16'h0005};
        tbl[5] = '{16'h3100, 1'b1, 1'b0, 5'b10000, 5'b00001, 1'b1, 16'h0000};
        tbl[6] = '{16'h103F, 1'b1, 1'b0, 5'b00001, 5'b00000, 1'b0, IMM_3F};
        tbl[7] = '{16'h7042, 1'b0, 1'b0, 5'b00000, 5'b00000, 1'b0, 16'h0000};
        tbl[8] = '{16'hF000, 1'b0, 1'b0, 5'b00000, 5'b00000, 1'b0, 16'h0000};
        tbl[9] = '{16'h2000, 1'b1, 1'b0, 5'b00001, 5'b00001, 1'b1, 16'h0000};
        cur_exp = '0;

        step(1'b0, 16'h0000, 1'b0, "reset");
        step(1'b1, 16'h00C5, 1'b0, "reset_start");
        step(1'b0, 16'h0000, 1'b1, "post_reset");

        for (int i = 0; i < 10; i++) begin
            issue(tbl[i], $sformatf("vec%0d", i));
            drain($sformatf("vec%0d", i));
        end

        // Reset asserted while in LATCH: outputs clear, no done afterwards.
        issue(tbl[0], "rst_mid");
        for (int i = 0; i < 4; i++) step(1'b0, 16'h0000, 1'b1, "rst_mid");
        step(1'b0, 16'h0000, 1'b0, "rst_mid_apply");
        for (int i = 0; i < 3; i++) step(1'b0, 16'h0000, 1'b1, "rst_mid_after");

        // Back-to-back with start held and instruction changed mid-op.
        issue(tbl[0], "b2b_a");
        for (int i = 0; i < 7; i++) step(1'b1, tbl[1].instr, 1'b1, "b2b_a");
        issue(tbl[1], "b2b_b");
        for (int i = 0; i < 8; i++) step(1'b1, 16'h7042, 1'b1, "b2b_b");
        step(1'b1, 16'h7042, 1'b1, "b2b_ignore");
        step(1'b0, 16'h0000, 1'b1, "b2b_idle");

        // Back-to-back from DONE into an illegal index.
        issue(tbl[4], "b2b_ill");
        for (int i = 0; i < 7; i++) step(1'b0, 16'h0000, 1'b1, "b2b_ill");
        issue(tbl[2], "b2b_ill_err");
        drain("b2b_ill_err");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
